// File: rtl/psram_cmd_tracker.sv
// psram_cmd_tracker
//
// Issue gate placed between the burst bus arbiter and the PSRAM memory controller.
// The controller has no busy output, so this block generates `ready` itself.
// After each accepted command, `ready` stays low for the controller's command gap (TCMD).
// A read also holds `ready` low until all READ_BEATS beats have returned. This stops an
// interleaved master from receiving read data that belongs to another master.
// If a read is still incomplete TIMEOUT clocks after its cmd_en, it is abandoned.
// Sticky error flags and a command counter are exposed for the debug bus.
//
// Ports:
//   clk           controller user clock
//   sys_resetn    asynchronous active-low reset
//   calib         controller init_calib, high when the controller is usable
//   cmd_en        one-cycle command strobe from the arbiter
//   cmd           1 = write, 0 = read, sampled with cmd_en
//   rd_data_valid controller read beat strobe
//   clear_errors  synchronous clear of the sticky error flags
//   ready         a command may be issued this cycle (combinational)
//   busy          a command is in flight
//   rd_done       one-cycle pulse on the clock after the last read beat
//   timeout_err   sticky: read abandoned after TIMEOUT clocks
//   protocol_err  sticky: cmd_en while ready was low
//   stray_err     sticky: read beat not belonging to an outstanding read
//   cmd_count     accepted commands, wrapping 16-bit counter

module psram_cmd_tracker #(
    parameter int unsigned TCMD       = 14,
    parameter int unsigned READ_BEATS = 4,
    parameter int unsigned TIMEOUT    = 63  // must be greater than TCMD
) (
    input  logic        clk,
    input  logic        sys_resetn,
    input  logic        calib,
    input  logic        cmd_en,
    input  logic        cmd,
    input  logic        rd_data_valid,
    input  logic        clear_errors,
    output logic        ready,
    output logic        busy,
    output logic        rd_done,
    output logic        timeout_err,
    output logic        protocol_err,
    output logic        stray_err,
    output logic [15:0] cmd_count
);

    localparam int unsigned GAP_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned BEAT_W = $clog2(READ_BEATS + 1);

    // Thresholds are compared against the incremented gap count. As a result, the
    // IDLE transition decided in cycle TCMD-1 after cmd_en puts ready high in cycle TCMD.
    localparam logic [GAP_W-1:0]  GAP_DONE    = GAP_W'(TCMD - 1);
    localparam logic [GAP_W-1:0]  GAP_TIMEOUT = GAP_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX     = GAP_W'(TIMEOUT);
    localparam logic [BEAT_W-1:0] BEATS_ALL   = BEAT_W'(READ_BEATS);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e              state_q, state_d;
    logic                is_write_q, is_write_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic                rd_done_q, rd_done_d;
    logic                timeout_err_q, timeout_err_d;
    logic                protocol_err_q, protocol_err_d;
    logic                stray_err_q, stray_err_d;
    logic [15:0]         cmd_count_q, cmd_count_d;

    logic                ready_int;
    logic                accept;
    logic                beat_expected;
    logic                beat_take;
    logic [BEAT_W-1:0]   beats_next;
    logic                reads_complete;
    logic [GAP_W-1:0]    gap_inc;
    logic                timeout_set;
    logic                protocol_set;
    logic                stray_set;

    assign ready_int = (state_q == StIdle) && calib;
    assign accept    = cmd_en && ready_int;

    // A beat counts only while a read is in flight and still short of its beat total.
    // A beat that arrives together with an accepted cmd_en is therefore stray.
    assign beat_expected  = (state_q == StBusy) && !is_write_q && (beats_q < BEATS_ALL);
    assign beat_take      = rd_data_valid && beat_expected;
    assign beats_next     = beats_q + BEAT_W'(beat_take);
    assign reads_complete = (beats_next == BEATS_ALL);
    assign gap_inc        = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

    assign protocol_set   = cmd_en && !ready_int;
    assign stray_set      = rd_data_valid && !beat_expected;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        gap_d       = gap_q;
        beats_d     = beats_q;
        cmd_count_d = cmd_count_q;
        timeout_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StBusy;
                    is_write_d  = cmd;
                    gap_d       = '0;
                    beats_d     = '0;
                    cmd_count_d = cmd_count_q + 16'd1;
                end
            end
            StBusy: begin
                gap_d   = gap_inc;
                beats_d = beats_next;
                // TIMEOUT > TCMD, so completion is checked first.
                // The timeout branch can then only fire for a read that is still short of beats.
                if ((gap_inc >= GAP_DONE) && (is_write_q || reads_complete)) begin
                    state_d = StIdle;
                end else if (!is_write_q && (gap_inc == GAP_TIMEOUT)) begin
                    state_d     = StIdle;
                    timeout_set = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rd_done_d      = beat_take && reads_complete;
        // The set term is ORed after the clear, so a new error wins over clear_errors.
        timeout_err_d  = (timeout_err_q  && !clear_errors) || timeout_set;
        protocol_err_d = (protocol_err_q && !clear_errors) || protocol_set;
        stray_err_d    = (stray_err_q    && !clear_errors) || stray_set;
    end

    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q        <= StIdle;
            is_write_q     <= 1'b0;
            gap_q          <= '0;
            beats_q        <= '0;
            rd_done_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
            stray_err_q    <= 1'b0;
            cmd_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            is_write_q     <= is_write_d;
            gap_q          <= gap_d;
            beats_q        <= beats_d;
            rd_done_q      <= rd_done_d;
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
            stray_err_q    <= stray_err_d;
            cmd_count_q    <= cmd_count_d;
        end
    end

    assign ready        = ready_int;
    assign busy         = (state_q == StBusy);
    assign rd_done      = rd_done_q;
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;
    assign stray_err    = stray_err_q;
    assign cmd_count    = cmd_count_q;

endmodule

// File: tb/tb_psram_cmd_tracker.sv
// Testbench for psram_cmd_tracker: a table of single-command transactions, hand-written
// corner sequences (protocol errors, error clear, async reset), then random traffic
// compared each cycle against a cycle-index based reference model.

module tb_psram_cmd_tracker;

    localparam int TCMD       = 14;
    localparam int READ_BEATS = 4;
    localparam int TIMEOUT    = 63;

    logic        clk = 1'b0;
    logic        sys_resetn;
    logic        calib;
    logic        cmd_en;
    logic        cmd;
    logic        rd_data_valid;
    logic        clear_errors;
    logic        ready;
    logic        busy;
    logic        rd_done;
    logic        timeout_err;
    logic        protocol_err;
    logic        stray_err;
    logic [15:0] cmd_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psram_cmd_tracker #(
        .TCMD       (TCMD),
        .READ_BEATS (READ_BEATS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .sys_resetn    (sys_resetn),
        .calib         (calib),
        .cmd_en        (cmd_en),
        .cmd           (cmd),
        .rd_data_valid (rd_data_valid),
        .clear_errors  (clear_errors),
        .ready         (ready),
        .busy          (busy),
        .rd_done       (rd_done),
        .timeout_err   (timeout_err),
        .protocol_err  (protocol_err),
        .stray_err     (stray_err),
        .cmd_count     (cmd_count)
    );

    typedef struct {
        bit is_write;
        int beat_start;
        int n_beats;
        int exp_ready;    // first cycle after cmd_en with ready high
        int exp_done;     // cycle of rd_done pulse, -1 for none
        bit exp_timeout;
        bit exp_stray;
    } txn_t;

    txn_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_pulse();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    // Starts at a negedge with the DUT idle; cycle 0 is the cmd_en cycle.
    task automatic run_txn(input bit is_write, input int beat_start, input int n_beats,
                           output int ready_at, output int done_at, output int done_cnt,
                           output int busy_bad);
        ready_at = -1;
        done_at  = -1;
        done_cnt = 0;
        busy_bad = 0;
        for (int c = 0; c <= 80; c++) begin
            if (c > 0 && ready === 1'b1 && ready_at < 0) ready_at = c;
            if (rd_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (busy === ready) busy_bad++;
            cmd_en        = (c == 0);
            cmd           = is_write;
            rd_data_valid = (c >= beat_start) && (c < beat_start + n_beats);
            @(negedge clk);
        end
        cmd_en        = 1'b0;
        rd_data_valid = 1'b0;
    endtask

    // Reference model state
    bit          m_busy, m_write, m_done, m_to, m_pe, m_st;
    int          m_idx;    // cycle index relative to the accepting cmd_en cycle
    int          m_beats;
    logic [15:0] m_count;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ready_at, done_at, done_cnt, busy_bad;
        logic [15:0] cnt0;

        tbl[0] = '{1,  0, 0, 14, -1, 0, 0};  // plain write
        tbl[1] = '{0, 10, 4, 14, 14, 0, 0};  // read, beats on time
        tbl[2] = '{0, 18, 4, 22, 22, 0, 0};  // late read
        tbl[3] = '{0,  1, 4, 14,  5, 0, 0};  // early beats
        tbl[4] = '{0, 10, 2, 63, -1, 1, 0};  // timeout, 2 beats only
        tbl[5] = '{0, 59, 4, 63, 63, 0, 0};  // last beat on the timeout cycle completes
        tbl[6] = '{0, 60, 4, 63, -1, 1, 1};  // one beat too late: timeout, then stray
        tbl[7] = '{0,  0, 5, 14,  5, 0, 1};  // beat with cmd_en is stray
        tbl[8] = '{0,  2, 6, 14,  6, 0, 1};  // extra beats after the fourth are stray
        tbl[9] = '{1,  3, 2, 14, -1, 0, 1};  // beats during a write are stray

        sys_resetn    = 1'b0;
        calib         = 1'b1;
        cmd_en        = 1'b0;
        cmd           = 1'b0;
        rd_data_valid = 1'b0;
        clear_errors  = 1'b0;
        repeat (3) @(negedge clk);
        sys_resetn = 1'b1;
        @(negedge clk);

        check("reset outputs", {ready, busy, rd_done, timeout_err, protocol_err, stray_err,
                                cmd_count}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) begin
            clear_pulse();
            cnt0 = cmd_count;
            run_txn(tbl[i].is_write, tbl[i].beat_start, tbl[i].n_beats,
                    ready_at, done_at, done_cnt, busy_bad);
            check($sformatf("txn%0d ready cycle", i), ready_at, tbl[i].exp_ready);
            check($sformatf("txn%0d rd_done cycle", i), done_at, tbl[i].exp_done);
            check($sformatf("txn%0d rd_done count", i), done_cnt, (tbl[i].exp_done < 0) ? 0 : 1);
            check($sformatf("txn%0d busy inverse", i), busy_bad, 0);
            check($sformatf("txn%0d timeout_err", i), timeout_err, tbl[i].exp_timeout);
            check($sformatf("txn%0d stray_err", i), stray_err, tbl[i].exp_stray);
            check($sformatf("txn%0d protocol_err", i), protocol_err, 0);
            check($sformatf("txn%0d cmd_count", i), cmd_count, cnt0 + 16'd1);
        end

        // Error recovery: flags left by the last timeout/stray case clear together
        run_txn(0, 60, 4, ready_at, done_at, done_cnt, busy_bad);
        check("recover timeout set", timeout_err, 1);
        check("recover stray set", stray_err, 1);
        clear_pulse();
        check("recover timeout clr", timeout_err, 0);
        check("recover stray clr", stray_err, 0);

        // Protocol violation during a write
        cnt0     = cmd_count;
        ready_at = -1;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0 && ready === 1'b1 && ready_at < 0) ready_at = c;
            cmd_en = (c == 0) || (c == 5);
            cmd    = 1'b1;
            @(negedge clk);
        end
        cmd_en = 1'b0;
        check("proto ready cycle", ready_at, 14);
        check("proto flag", protocol_err, 1);
        check("proto cmd_count", cmd_count, cnt0 + 16'd1);

        // calib low at idle, then set-wins against clear
        clear_pulse();
        check("proto cleared", protocol_err, 0);
        cnt0  = cmd_count;
        calib = 1'b0;
        #1;
        check("calib low ready", ready, 0);
        cmd_en = 1'b1;
        @(negedge clk);
        cmd_en = 1'b0;
        check("calib low proto", protocol_err, 1);
        check("calib low count", cmd_count, cnt0);
        check("calib low busy", busy, 0);
        clear_errors = 1'b1;
        cmd_en       = 1'b1;
        @(negedge clk);
        cmd_en = 1'b0;
        check("set wins clear", protocol_err, 1);
        @(negedge clk);
        clear_errors = 1'b0;
        check("clear alone", protocol_err, 0);
        calib = 1'b1;
        #1;
        check("calib high ready", ready, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a read
        clear_pulse();
        for (int c = 0; c <= 6; c++) begin
            cmd_en        = (c == 0) || (c == 3);
            cmd           = 1'b0;
            rd_data_valid = (c == 4) || (c == 5);
            @(negedge clk);
        end
        cmd_en        = 1'b0;
        rd_data_valid = 1'b0;
        check("pre-reset busy", busy, 1);
        #2;
        sys_resetn = 1'b0;
        calib      = 1'b0;
        #1;
        check("async reset outputs", {ready, busy, rd_done, timeout_err, protocol_err, stray_err,
                                      cmd_count}, 32'd0);
        @(negedge clk);
        sys_resetn = 1'b1;
        @(negedge clk);
        check("post reset ready calib0", ready, 0);
        calib = 1'b1;
        #1;
        check("post reset ready calib1", ready, 1);
        @(negedge clk);
        run_txn(0, 10, 4, ready_at, done_at, done_cnt, busy_bad);
        check("resend ready cycle", ready_at, 14);
        check("resend rd_done cycle", done_at, 14);
        check("resend cmd_count", cmd_count, 16'd1);

        // Randomized traffic against the reference model
        sys_resetn = 1'b0;
        calib      = 1'b1;
        @(negedge clk);
        sys_resetn = 1'b1;
        m_busy  = 0;
        m_write = 0;
        m_done  = 0;
        m_to    = 0;
        m_pe    = 0;
        m_st    = 0;
        m_idx   = 0;
        m_beats = 0;
        m_count = 16'd0;
        for (int n = 0; n < 4000; n++) begin
            bit ready_now, counted, set_pe, set_st, set_to, n_done;
            check($sformatf("random cycle %0d", n),
                  {ready, busy, rd_done, timeout_err, protocol_err, stray_err, cmd_count},
                  {!m_busy && calib, m_busy, m_done, m_to, m_pe, m_st, m_count});

            if ($urandom_range(0, 99) == 0) calib = ~calib;
            cmd_en        = ($urandom_range(0, 4) == 0);
            cmd           = $urandom_range(0, 1) != 0;
            rd_data_valid = ($urandom_range(0, 2) == 0);
            clear_errors  = ($urandom_range(0, 24) == 0);

            ready_now = !m_busy && calib;
            set_pe    = cmd_en && !ready_now;
            counted   = rd_data_valid && m_busy && !m_write && (m_beats < READ_BEATS);
            set_st    = rd_data_valid && !counted;
            set_to    = 0;
            n_done    = 0;
            if (m_busy) begin
                m_idx++;
                if (counted) m_beats++;
                n_done = counted && (m_beats == READ_BEATS);
                if (m_idx >= TCMD && (m_write || m_beats == READ_BEATS)) begin
                    m_busy = 0;
                end else if (!m_write && m_idx == TIMEOUT) begin
                    m_busy = 0;
                    set_to = 1;
                end
            end else if (cmd_en && calib) begin
                m_busy  = 1;
                m_write = cmd;
                m_idx   = 1;
                m_beats = 0;
                m_count = m_count + 16'd1;
            end
            m_done = n_done;
            m_to   = (m_to && !clear_errors) || set_to;
            m_pe   = (m_pe && !clear_errors) || set_pe;
            m_st   = (m_st && !clear_errors) || set_st;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
